uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//   Consumes bytes from the UART receiver (one-cycle rx_valid strobe with the byte on rx_data)
//   and decodes ASCII commands for the digital clock core. Handles one-byte commands
//   (clear, mode toggle) and a time-set command "T" + HHMMSS + CR/LF. Emits one-cycle command
//   pulses plus a validated, binary-coded time value.
// PARAMETERS
//   TIMEOUT_CYCLES  100_000_000  max clk cycles between bytes of a multi-byte command before abort
// PORTS
//   clk         in   1  system clock
//   rst         in   1  asynchronous, active-high reset
//   rx_data     in   8  received byte; valid only while rx_valid=1
//   rx_valid    in   1  one-cycle strobe, one byte per strobe
//   set_valid   out  1  one-cycle pulse: set_hour/min/sec hold a new validated time
//   set_hour    out  5  hour 0..23, binary
//   set_min     out  6  minute 0..59, binary
//   set_sec     out  6  second 0..59, binary
//   clr_pulse   out  1  one-cycle pulse on 'C'/'c'
//   mode_pulse  out  1  one-cycle pulse on 'M'/'m'
//   err_pulse   out  1  one-cycle pulse on a malformed command, range error or timeout
//   busy        out  1  high while a time-set command is in progress (state != IDLE)
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0; digit regs, digit index, timeout counter cleared.
//   - All outputs registered: any pulse is asserted in the cycle after the rx_valid cycle
//     that caused it, and lasts exactly one cycle. At most one of set_valid/clr/mode/err per byte.
//   - set_hour/min/sec update only together with set_valid; they hold their value otherwise.
//   - States: IDLE, DIGITS, TERM.
//   - IDLE: rx_valid & ('C'|'c') -> clr_pulse; ('M'|'m') -> mode_pulse; ('T'|'t') -> DIGITS,
//     idx=0, timer=0; 0x0D/0x0A/0x20 ignored; any other byte -> err_pulse, stay IDLE.
//   - DIGITS: rx_valid & byte in '0'..'9' -> store (byte-0x30) in digit[idx], idx+1; after
//     the 6th digit (idx==5) -> TERM. Non-digit -> err_pulse, IDLE, byte discarded (not
//     re-decoded as a command).
//   - TERM: rx_valid & (0x0D|0x0A) -> range check; pass -> set_valid, IDLE; fail ->
//     err_pulse, IDLE. Any other byte -> err_pulse, IDLE.
//   - Range check: H=d0*10+d1 <= 23, M=d2*10+d3 <= 59, S=d4*10+d5 <= 59. Conversion uses
//     d*10 = (d<<3)+(d<<1); result widths 5/6/6 bits; no truncation since checked values fit.
//   - Timeout: in DIGITS/TERM the timer counts every clk and clears on each rx_valid; on
//     reaching TIMEOUT_CYCLES-1 with no rx_valid -> err_pulse, IDLE. rx_valid in that same
//     cycle wins (byte processed, timer cleared). Counter width $clog2(TIMEOUT_CYCLES).
//   - Timer is held at 0 in IDLE; no timeout while IDLE.
//   - Back-to-back rx_valid on consecutive cycles must be accepted (no bytes dropped).
//   - rst mid-command: partial command discarded, no pulse generated, IDLE on release.
//   - busy = (state != IDLE), registered with state.
// TESTING
//   1. Bytes "T","1","2","3","4","5","6",0x0D -> one set_valid cycle after CR, hour=12,
//      min=34, sec=56; busy high from after 'T' until the pulse cycle.
//   2. "t235959\n" -> set_valid with 23/59/59; then "T240000\r" -> err_pulse, set_* keep 23/59/59.
//   3. 'C', then 'm', on consecutive cycles -> clr_pulse then mode_pulse, each one cycle; 'x' -> err_pulse.
//   4. "T12a" -> err_pulse after 'a', IDLE; following 'C' -> clr_pulse (recovery).
//      "T1234567" -> err_pulse on '7' (TERM expects CR/LF).
//   5. TIMEOUT_CYCLES=16: "T12" then silence -> err_pulse 16 cycles after last rx_valid,
//      busy drops; a byte arriving in cycle 15 resets the timer instead.
//   6. Assert rst after "T123" -> all outputs 0, no pulse; after release "T000000\r" -> set_valid 0/0/0.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - byte input and command/time outputs of the UART command parser
interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       set_valid;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       clr_pulse;
    logic       mode_pulse;
    logic       err_pulse;
    logic       busy;

    modport master (
        output rx_data, rx_valid,
        input  set_valid, set_hour, set_min, set_sec,
        input  clr_pulse, mode_pulse, err_pulse, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output set_valid, set_hour, set_min, set_sec,
        output clr_pulse, mode_pulse, err_pulse, busy
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - ASCII command decoder: C/M single-byte commands, T+HHMMSS+CR/LF time set
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_parser_if.slave  bus
);

    localparam int             TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CH_C_UP = 8'h43, CH_C_LO = 8'h63;
    localparam logic [7:0] CH_M_UP = 8'h4D, CH_M_LO = 8'h6D;
    localparam logic [7:0] CH_T_UP = 8'h54, CH_T_LO = 8'h74;
    localparam logic [7:0] CH_CR   = 8'h0D, CH_LF   = 8'h0A, CH_SP = 8'h20;

    typedef enum logic [1:0] {IDLE, DIGITS, TERM} state_t;

    state_t        state, state_nxt;
    logic [3:0]    digit [0:5];
    logic [2:0]    idx;
    logic [TW-1:0] timer;

    logic          set_nxt, clr_nxt, mode_nxt, err_nxt;
    logic          is_digit, is_eol, timeout, range_ok;
    logic [6:0]    hour_val, min_val, sec_val;

    assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign is_eol   = (bus.rx_data == CH_CR) || (bus.rx_data == CH_LF);
    // a byte arriving in the last timer cycle takes precedence over the timeout
    assign timeout  = (state != IDLE) && !bus.rx_valid && (timer == T_LAST);

    // d*10 built as (d<<3)+(d<<1); 7 bits covers 99, the largest two-digit value
    assign hour_val = {digit[0], 3'b000} + {2'b00, digit[0], 1'b0} + {3'b000, digit[1]};
    assign min_val  = {digit[2], 3'b000} + {2'b00, digit[2], 1'b0} + {3'b000, digit[3]};
    assign sec_val  = {digit[4], 3'b000} + {2'b00, digit[4], 1'b0} + {3'b000, digit[5]};
    assign range_ok = (hour_val <= 7'd23) && (min_val <= 7'd59) && (sec_val <= 7'd59);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.rx_valid && ((bus.rx_data == CH_T_UP) || (bus.rx_data == CH_T_LO))) begin
                    state_nxt = DIGITS;
                end
            end
            DIGITS: begin
                if (timeout) begin
                    state_nxt = IDLE;
                end else if (bus.rx_valid) begin
                    if (!is_digit) begin
                        state_nxt = IDLE;
                    end else if (idx == 3'd5) begin
                        state_nxt = TERM;
                    end
                end
            end
            TERM: begin
                if (timeout || bus.rx_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        set_nxt  = 1'b0;
        clr_nxt  = 1'b0;
        mode_nxt = 1'b0;
        err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        CH_C_UP, CH_C_LO:       clr_nxt  = 1'b1;
                        CH_M_UP, CH_M_LO:       mode_nxt = 1'b1;
                        CH_T_UP, CH_T_LO:       ;
                        CH_CR, CH_LF, CH_SP:    ;
                        default:                err_nxt  = 1'b1;
                    endcase
                end
            end
            DIGITS: begin
                if (timeout || (bus.rx_valid && !is_digit)) begin
                    err_nxt = 1'b1;
                end
            end
            TERM: begin
                if (timeout) begin
                    err_nxt = 1'b1;
                end else if (bus.rx_valid) begin
                    if (is_eol && range_ok) begin
                        set_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.busy       <= 1'b0;
            bus.set_valid  <= 1'b0;
            bus.clr_pulse  <= 1'b0;
            bus.mode_pulse <= 1'b0;
            bus.err_pulse  <= 1'b0;
            bus.set_hour   <= 5'd0;
            bus.set_min    <= 6'd0;
            bus.set_sec    <= 6'd0;
            idx            <= 3'd0;
            timer          <= '0;
            for (int i = 0; i < 6; i++) begin
                digit[i] <= 4'd0;
            end
        end else begin
            bus.busy       <= (state_nxt != IDLE);
            bus.set_valid  <= set_nxt;
            bus.clr_pulse  <= clr_nxt;
            bus.mode_pulse <= mode_nxt;
            bus.err_pulse  <= err_nxt;
            if (set_nxt) begin
                bus.set_hour <= hour_val[4:0];
                bus.set_min  <= min_val[5:0];
                bus.set_sec  <= sec_val[5:0];
            end

            if (state == IDLE) begin
                idx <= 3'd0;
            end else if ((state == DIGITS) && bus.rx_valid && is_digit) begin
                idx <= idx + 3'd1;
                for (int i = 0; i < 6; i++) begin
                    if (idx == 3'(i)) begin
                        digit[i] <= bus.rx_data[3:0];
                    end
                end
            end

            // timer idles at 0 outside a command and restarts on every received byte
            if ((state_nxt == IDLE) || bus.rx_valid) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] pl;
    assign pl = {bus.set_valid, bus.clr_pulse, bus.mode_pulse, bus.err_pulse};

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
        end
    endtask

    task automatic test_reset;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_run++;
        if ({pl, bus.busy, bus.set_hour, bus.set_min, bus.set_sec} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h exp 0", {pl, bus.busy, bus.set_hour, bus.set_min, bus.set_sec});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_run++;
        if ({pl, bus.busy} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_release got %b exp 00000", {pl, bus.busy});
        end
    endtask

    task automatic test_time_set;
        send("T");
        n_run++;
        if ({pl, bus.busy} !== 5'b00001) begin
            n_fail++;
            $display("FAIL ts_busy_after_T got %b exp 00001", {pl, bus.busy});
        end
        send_str("123456");
        n_run++;
        if ({pl, bus.busy} !== 5'b00001) begin
            n_fail++;
            $display("FAIL ts_busy_after_digits got %b exp 00001", {pl, bus.busy});
        end
        send(8'h0D);
        n_run++;
        if ({pl, bus.busy} !== 5'b10000 || bus.set_hour !== 5'd12 || bus.set_min !== 6'd34 || bus.set_sec !== 6'd56) begin
            n_fail++;
            $display("FAIL ts_set got pl=%b busy=%b %0d:%0d:%0d exp pl=1000 busy=0 12:34:56",
                     pl, bus.busy, bus.set_hour, bus.set_min, bus.set_sec);
        end
        @(negedge clk);
        n_run++;
        if (pl !== 4'b0000 || bus.set_hour !== 5'd12) begin
            n_fail++;
            $display("FAIL ts_one_cycle got pl=%b hour=%0d exp pl=0000 hour=12", pl, bus.set_hour);
        end
    endtask

    task automatic test_range;
        send_str("t235959\n");
        n_run++;
        if (pl !== 4'b1000 || bus.set_hour !== 5'd23 || bus.set_min !== 6'd59 || bus.set_sec !== 6'd59) begin
            n_fail++;
            $display("FAIL rng_max got pl=%b %0d:%0d:%0d exp pl=1000 23:59:59",
                     pl, bus.set_hour, bus.set_min, bus.set_sec);
        end
        send_str("T240000\r");
        n_run++;
        if ({pl, bus.busy} !== 5'b00010 || bus.set_hour !== 5'd23 || bus.set_min !== 6'd59 || bus.set_sec !== 6'd59) begin
            n_fail++;
            $display("FAIL rng_hour24 got pl=%b busy=%b %0d:%0d:%0d exp pl=0001 busy=0 23:59:59",
                     pl, bus.busy, bus.set_hour, bus.set_min, bus.set_sec);
        end
        send_str("T006000\r");
        n_run++;
        if (pl !== 4'b0001 || bus.set_min !== 6'd59) begin
            n_fail++;
            $display("FAIL rng_min60 got pl=%b min=%0d exp pl=0001 min=59", pl, bus.set_min);
        end
    endtask

    task automatic test_single_cmds;
        @(negedge clk);
        bus.rx_data  = "C";
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_data  = "m";
        n_run++;
        if (pl !== 4'b0100) begin
            n_fail++;
            $display("FAIL cmd_clr got %b exp 0100", pl);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        n_run++;
        if (pl !== 4'b0010) begin
            n_fail++;
            $display("FAIL cmd_mode got %b exp 0010", pl);
        end
        @(negedge clk);
        n_run++;
        if (pl !== 4'b0000) begin
            n_fail++;
            $display("FAIL cmd_pulses_end got %b exp 0000", pl);
        end
        send("x");
        n_run++;
        if ({pl, bus.busy} !== 5'b00010) begin
            n_fail++;
            $display("FAIL cmd_err_x got %b exp 00010", {pl, bus.busy});
        end
        send(" ");
        n_run++;
        if ({pl, bus.busy} !== 5'b00000) begin
            n_fail++;
            $display("FAIL cmd_space_ignored got %b exp 00000", {pl, bus.busy});
        end
    endtask

    task automatic test_malformed;
        send_str("T12a");
        n_run++;
        if ({pl, bus.busy} !== 5'b00010) begin
            n_fail++;
            $display("FAIL mal_nondigit got %b exp 00010", {pl, bus.busy});
        end
        send("C");
        n_run++;
        if ({pl, bus.busy} !== 5'b01000) begin
            n_fail++;
            $display("FAIL mal_recover got %b exp 01000", {pl, bus.busy});
        end
        send_str("T1C");
        n_run++;
        if ({pl, bus.busy} !== 5'b00010) begin
            n_fail++;
            $display("FAIL mal_not_redecoded got %b exp 00010", {pl, bus.busy});
        end
        send_str("T123456");
        n_run++;
        if ({pl, bus.busy} !== 5'b00001) begin
            n_fail++;
            $display("FAIL mal_in_term got %b exp 00001", {pl, bus.busy});
        end
        send("7");
        n_run++;
        if ({pl, bus.busy} !== 5'b00010) begin
            n_fail++;
            $display("FAIL mal_seventh_digit got %b exp 00010", {pl, bus.busy});
        end
    endtask

    task automatic test_timeout;
        logic early;
        send_str("T12");
        early = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (pl !== 4'b0000 || bus.busy !== 1'b1) early = 1'b1;
        end
        n_run++;
        if (early) begin
            n_fail++;
            $display("FAIL to_early got early=1 exp early=0");
        end
        @(negedge clk);
        n_run++;
        if ({pl, bus.busy} !== 5'b00010) begin
            n_fail++;
            $display("FAIL to_expire got %b exp 00010", {pl, bus.busy});
        end
        @(negedge clk);
        n_run++;
        if ({pl, bus.busy} !== 5'b00000) begin
            n_fail++;
            $display("FAIL to_after got %b exp 00000", {pl, bus.busy});
        end

        send_str("T12");
        repeat (15) @(negedge clk);
        bus.rx_data  = "3";
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        n_run++;
        if ({pl, bus.busy} !== 5'b00001) begin
            n_fail++;
            $display("FAIL to_last_cycle_byte got %b exp 00001", {pl, bus.busy});
        end
        send_str("456\r");
        n_run++;
        if (pl !== 4'b1000 || bus.set_hour !== 5'd12 || bus.set_min !== 6'd34 || bus.set_sec !== 6'd56) begin
            n_fail++;
            $display("FAIL to_resume_set got pl=%b %0d:%0d:%0d exp pl=1000 12:34:56",
                     pl, bus.set_hour, bus.set_min, bus.set_sec);
        end
    endtask

    task automatic test_back_to_back;
        string s;
        s = "T081530\r";
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.rx_data  = s[i];
            bus.rx_valid = 1'b1;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        n_run++;
        if (pl !== 4'b1000 || bus.set_hour !== 5'd8 || bus.set_min !== 6'd15 || bus.set_sec !== 6'd30) begin
            n_fail++;
            $display("FAIL b2b_set got pl=%b %0d:%0d:%0d exp pl=1000 8:15:30",
                     pl, bus.set_hour, bus.set_min, bus.set_sec);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        send_str("T123");
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_run++;
        if ({pl, bus.busy, bus.set_hour, bus.set_min, bus.set_sec} !== 22'd0) begin
            n_fail++;
            $display("FAIL rm_outputs got %h exp 0", {pl, bus.busy, bus.set_hour, bus.set_min, bus.set_sec});
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if ({pl, bus.busy} !== 5'd0) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if ({pl, bus.busy} !== 5'd0) seen = 1'b1;
        end
        n_run++;
        if (seen) begin
            n_fail++;
            $display("FAIL rm_no_pulse got activity=1 exp activity=0");
        end
        send_str("T000000\r");
        n_run++;
        if ({pl, bus.busy} !== 5'b10000 || bus.set_hour !== 5'd0 || bus.set_min !== 6'd0 || bus.set_sec !== 6'd0) begin
            n_fail++;
            $display("FAIL rm_set_zero got pl=%b busy=%b %0d:%0d:%0d exp pl=1000 busy=0 0:0:0",
                     pl, bus.busy, bus.set_hour, bus.set_min, bus.set_sec);
        end
    endtask

    initial begin
        test_reset;
        test_time_set;
        test_range;
        test_single_cmds;
        test_malformed;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
